// File: rtl/dmem_dma_engine_pkg.sv
// Shared definitions for the data-memory DMA engine: FSM state encodings and job mode constants.
package dmem_dma_engine_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_FILL = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/dmem_dma_engine.sv
// Block COPY / FILL master for the single-port data memory; owns the port while mem_req is high.
// Job interface: start is a one-shot request honoured only in IDLE; done is a single-cycle pulse.
module dmem_dma_engine
  import dmem_dma_engine_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 5,
  parameter int MEM_DATA_WIDTH = 16,
  parameter int MEM_NUMBER     = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      mode,
  input  logic [MEM_ADDR_WIDTH-1:0] src_addr,
  input  logic [MEM_ADDR_WIDTH-1:0] dst_addr,
  input  logic [MEM_ADDR_WIDTH:0]   len,
  input  logic [MEM_DATA_WIDTH-1:0] fill_data,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_req,
  output logic                      MemWEn,
  output logic [MEM_ADDR_WIDTH-1:0] addr,
  output logic [MEM_DATA_WIDTH-1:0] dataw,
  input  logic [MEM_DATA_WIDTH-1:0] datar,
  output logic [2:0]                dbg_state
);

  localparam int CW = $clog2(MEM_NUMBER) + 1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [MEM_ADDR_WIDTH-1:0] PTR_ONE = MEM_ADDR_WIDTH'(1);

  logic [2:0]                state;
  logic [MEM_ADDR_WIDTH-1:0] src_ptr;
  logic [MEM_ADDR_WIDTH-1:0] dst_ptr;
  logic [CW-1:0]             cnt;
  logic [MEM_DATA_WIDTH-1:0] rd_buf;
  logic [MEM_DATA_WIDTH-1:0] fill_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      src_ptr  <= '0;
      dst_ptr  <= '0;
      cnt      <= '0;
      rd_buf   <= '0;
      fill_reg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src_ptr  <= src_addr;
            dst_ptr  <= dst_addr;
            cnt      <= len;
            fill_reg <= fill_data;
            if (len == '0)             state <= S_DONE;
            else if (mode == MODE_FILL) state <= S_FILL;
            else                        state <= S_RD;
          end
        end
        S_RD: begin
          rd_buf  <= datar;
          src_ptr <= src_ptr + PTR_ONE;
          state   <= S_WR;
        end
        S_WR: begin
          dst_ptr <= dst_ptr + PTR_ONE;
          cnt     <= cnt - CNT_ONE;
          state   <= (cnt == CNT_ONE) ? S_DONE : S_RD;
        end
        S_FILL: begin
          dst_ptr <= dst_ptr + PTR_ONE;
          cnt     <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory-side outputs depend only on state and registered pointers, never on start/datar.
  always_comb begin
    busy    = (state != S_IDLE);
    mem_req = busy;
    done    = (state == S_DONE);
    MemWEn  = (state == S_WR) || (state == S_FILL);
    addr    = '0;
    dataw   = '0;
    case (state)
      S_RD:   addr = src_ptr;
      S_WR: begin
        addr  = dst_ptr;
        dataw = rd_buf;
      end
      S_FILL: begin
        addr  = dst_ptr;
        dataw = fill_reg;
      end
      default: begin
        addr  = '0;
        dataw = '0;
      end
    endcase
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_dma_engine.sv
// Bench for dmem_dma_engine: data memory behind a 2:1 port mux, directed and random jobs vs. a word-level model.
module tb_dmem_dma_engine;
  import dmem_dma_engine_pkg::*;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int NW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] dst_addr = '0;
  logic [AW:0]   len = '0;
  logic [DW-1:0] fill_data = '0;
  logic          busy, done, mem_req, MemWEn;
  logic [AW-1:0] addr;
  logic [DW-1:0] dataw, datar;
  logic [2:0]    dbg_state;

  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;

  logic [DW-1:0] mem [NW];
  logic [DW-1:0] ref_mem [NW];
  logic [AW-1:0] m_addr;
  logic          m_we;
  logic [DW-1:0] m_wdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_dma_engine #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .MEM_NUMBER(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .fill_data(fill_data), .busy(busy), .done(done),
    .mem_req(mem_req), .MemWEn(MemWEn), .addr(addr), .dataw(dataw), .datar(datar),
    .dbg_state(dbg_state)
  );

  assign m_addr  = mem_req ? addr   : cpu_addr;
  assign m_we    = mem_req ? MemWEn : cpu_we;
  assign m_wdata = mem_req ? dataw  : cpu_wdata;
  assign datar   = mem[m_addr];

  always @(posedge clk) if (m_we) mem[m_addr] <= m_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Reference: one word per step in ascending order, so dst>src overlap propagates.
  task automatic model_job(input logic m, input int s, input int d, input int n, input logic [DW-1:0] v);
    for (int i = 0; i < n; i++)
      ref_mem[(d + i) % NW] = (m == MODE_FILL) ? v : ref_mem[(s + i) % NW];
  endtask

  task automatic check_mem(input string tag);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < NW; i++)
      if (mem[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    check({tag, "_mem_bad_words"}, bad, 0);
    if (first >= 0) $display("  first differing word %0d: dut=%0h model=%0h", first, mem[first], ref_mem[first]);
  endtask

  // Issues a job at edge k and watches the cycles after it; optionally pulses start mid-job.
  task automatic run_job(input string tag, input logic m, input int s, input int d, input int n,
                         input logic [DW-1:0] v, input bit poke);
    int cyc, done_cyc, done_cnt, we_cnt, exp_done;
    exp_done = (n == 0) ? 1 : ((m == MODE_FILL) ? n + 1 : 2 * n + 1);
    @(negedge clk);
    start = 1'b1; mode = m; src_addr = AW'(s); dst_addr = AW'(d); len = (AW+1)'(n); fill_data = v;
    @(posedge clk); #1;
    start = 1'b0;
    src_addr = AW'($urandom); dst_addr = AW'($urandom); len = (AW+1)'($urandom); fill_data = DW'($urandom);
    mode = 1'($urandom);
    cyc = 1; done_cyc = 0; done_cnt = 0; we_cnt = 0;
    while (cyc <= 200) begin
      if (MemWEn) we_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (done) break;
      if (poke && cyc == 2) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_we_cycles"}, we_cnt, n);
    @(posedge clk); #1;
    if (done) done_cnt++;
    check({tag, "_single_done"}, done_cnt, 1);
    check({tag, "_idle_after"}, {busy, MemWEn, mem_req}, 3'b000);
    model_job(m, s, d, n, v);
    check_mem(tag);
  endtask

  initial begin
    int s, d, n;
    logic m;
    for (int i = 0; i < NW; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    #12;
    check("reset_busy_done_req_we", {busy, done, mem_req, MemWEn}, 4'b0000);
    check("reset_addr", addr, 0);
    check("reset_dataw", dataw, 0);
    check("reset_state", dbg_state, S_IDLE);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < NW; i++) cpu_write(AW'(i), DW'($urandom));
    cpu_write(2, 16'hA); cpu_write(3, 16'hB); cpu_write(4, 16'hC); cpu_write(5, 16'hD);

    run_job("copy4", MODE_COPY, 2, 10, 4, 16'h0, 1'b0);
    check("copy4_word13", mem[13], 16'hD);
    run_job("fill_wrap", MODE_FILL, 0, 28, 6, 16'hBEEF, 1'b0);
    check("fill_wrap_word1", mem[1], 16'hBEEF);
    run_job("len0", MODE_COPY, 3, 7, 0, 16'h0, 1'b0);
    run_job("start_busy", MODE_COPY, 20, 24, 3, 16'h0, 1'b1);
    cpu_write(0, 16'h5);
    run_job("overlap", MODE_COPY, 0, 1, 3, 16'h0, 1'b0);
    check("overlap_word3", mem[3], 16'h5);
    run_job("fill_full", MODE_FILL, 0, 17, 32, 16'h1234, 1'b0);
    for (int i = 0; i < NW; i++) cpu_write(AW'(i), DW'($urandom));
    run_job("copy_full", MODE_COPY, 9, 9, 32, 16'h0, 1'b0);

    // Abandon a COPY during the write of its third word.
    @(negedge clk);
    start = 1'b1; mode = MODE_COPY; src_addr = 0; dst_addr = 16; len = 8;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
    check("rst_mid_pre_we", MemWEn, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_we_drop", MemWEn, 1'b0);
    check("rst_mid_busy_done", {busy, done}, 2'b00);
    model_job(MODE_COPY, 0, 16, 2, 16'h0);
    @(negedge clk); rst_n = 1'b1;
    check("rst_mid_done_absent", done, 1'b0);
    check_mem("rst_mid");
    run_job("restart", MODE_COPY, 0, 16, 8, 16'h0, 1'b0);

    for (int j = 0; j < 12; j++) begin
      m = 1'($urandom);
      s = $urandom_range(0, NW - 1);
      d = $urandom_range(0, NW - 1);
      n = $urandom_range(0, NW);
      run_job($sformatf("rand%0d", j), m, s, d, n, DW'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
